alu_operand_pipe: RTL and testbench

Parametrised N-way operand selector for the MCU ALU datapath; the generalised successor of the 2:1 ALU operand mux. It selects one of NUM_IN operand words, registers the result in a single output stage, and uses a valid/ready handshake so the ALU can stall the operand path. It also flags out-of-range selects.

---
 rtl/alu_operand_pipe.sv | 96 +++++++++
 tb/tb_alu_operand_pipe.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_pipe.sv
// alu_operand_pipe: N-way operand select, one registered valid/ready output stage.
// Define OPSEL_SKID_EN to add a skid register and make IN_READY a flop.
module alu_operand_pipe #(
    parameter int WIDTH = 8,
    parameter int NUM_IN = 4,
    localparam int SEL_W = $clog2(NUM_IN)
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [NUM_IN*WIDTH-1:0] IN_BUS,
    input  logic [SEL_W-1:0]        MUX_SEL,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    output logic [WIDTH-1:0]        MUX_OUT,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic                    SEL_ERR
);
    logic [WIDTH-1:0] sel_word;
    logic             sel_bad;
    logic             in_xfer;

    // An unmatched select falls back to operand 0 and is flagged.
    always_comb begin
        sel_word = IN_BUS[WIDTH-1:0];
        sel_bad  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (MUX_SEL == SEL_W'(k)) begin
                sel_word = IN_BUS[k*WIDTH +: WIDTH];
                sel_bad  = 1'b0;
            end
        end
    end

    assign in_xfer = IN_VALID && IN_READY;

`ifdef OPSEL_SKID_EN
    logic             ready_q;
    logic             skid_full;
    logic [WIDTH-1:0] skid_word;
    logic             skid_err;
    logic             out_free;

    assign IN_READY = ready_q;
    assign out_free = !OUT_VALID || OUT_READY;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            MUX_OUT   <= '0;
            SEL_ERR   <= 1'b0;
            OUT_VALID <= 1'b0;
            skid_full <= 1'b0;
            skid_word <= '0;
            skid_err  <= 1'b0;
            ready_q   <= 1'b0;
        end else if (skid_full) begin
            if (OUT_READY) begin
                MUX_OUT   <= skid_word;
                SEL_ERR   <= skid_err;
                skid_full <= 1'b0;
                ready_q   <= 1'b1;
            end
        end else if (in_xfer && !out_free) begin
            skid_word <= sel_word;
            skid_err  <= sel_bad;
            skid_full <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            if (in_xfer) begin
                MUX_OUT   <= sel_word;
                SEL_ERR   <= sel_bad;
                OUT_VALID <= 1'b1;
            end else if (OUT_READY) begin
                OUT_VALID <= 1'b0;
            end
        end
    end
`else
    assign IN_READY = !OUT_VALID || OUT_READY;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            MUX_OUT   <= '0;
            SEL_ERR   <= 1'b0;
            OUT_VALID <= 1'b0;
        end else if (in_xfer) begin
            MUX_OUT   <= sel_word;
            SEL_ERR   <= sel_bad;
            OUT_VALID <= 1'b1;
        end else if (OUT_VALID && OUT_READY) begin
            OUT_VALID <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_alu_operand_pipe.sv
// tb_alu_operand_pipe: directed vectors plus a scoreboarded random stream.
module tb_alu_operand_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_bus = '0;
    logic [1:0]  mux_sel = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  mux_out;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        sel_err;

    logic [23:0] in_bus3 = '0;
    logic [1:0]  mux_sel3 = '0;
    logic        in_valid3 = 1'b0;
    logic        in_ready3;
    logic [7:0]  mux_out3;
    logic        out_valid3;
    logic        out_ready3 = 1'b0;
    logic        sel_err3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_operand_pipe #(.WIDTH(8), .NUM_IN(4)) u_dut (
        .CLK(clk), .RST_N(rst_n), .IN_BUS(in_bus), .MUX_SEL(mux_sel),
        .IN_VALID(in_valid), .IN_READY(in_ready), .MUX_OUT(mux_out),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .SEL_ERR(sel_err)
    );

    alu_operand_pipe #(.WIDTH(8), .NUM_IN(3)) u_dut3 (
        .CLK(clk), .RST_N(rst_n), .IN_BUS(in_bus3), .MUX_SEL(mux_sel3),
        .IN_VALID(in_valid3), .IN_READY(in_ready3), .MUX_OUT(mux_out3),
        .OUT_VALID(out_valid3), .OUT_READY(out_ready3), .SEL_ERR(sel_err3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [8:0] q[$];
    logic [8:0] head;
    logic [7:0] hold_w;
    logic       hold_e;
    logic       stall;
    logic       ixf;
    logic       oxf;

    initial begin
        step();
        step();
        chk("rst_out", 32'(mux_out), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_err", 32'(sel_err), 32'h0);
`ifdef OPSEL_SKID_EN
        chk("rst_ready", 32'(in_ready), 32'h0);
`else
        chk("rst_ready", 32'(in_ready), 32'h1);
`endif
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", 32'(in_ready), 32'h1);

        // single word, select 2
        in_bus = 32'h44332211;
        mux_sel = 2'd2;
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        chk("t1_out", 32'(mux_out), 32'h33);
        chk("t1_valid", 32'(out_valid), 32'h1);
        chk("t1_err", 32'(sel_err), 32'h0);

        // back-to-back stream
        for (int i = 0; i < 4; i++) begin
            mux_sel = 2'(i);
            step();
            chk("t2_out", 32'(mux_out), 32'(8'h11 * (i + 1)));
            chk("t2_valid", 32'(out_valid), 32'h1);
        end

        // stall after 0x22
        mux_sel = 2'd0;
        step();
        mux_sel = 2'd1;
        step();
        chk("t3_load", 32'(mux_out), 32'h22);
        out_ready = 1'b0;
        mux_sel = 2'd2;
        #1;
`ifdef OPSEL_SKID_EN
        chk("t3_ready0", 32'(in_ready), 32'h1);
`else
        chk("t3_ready0", 32'(in_ready), 32'h0);
`endif
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_hold", 32'(mux_out), 32'h22);
            chk("t3_valid", 32'(out_valid), 32'h1);
            chk("t3_ready", 32'(in_ready), 32'h0);
        end
        out_ready = 1'b1;
`ifdef OPSEL_SKID_EN
        in_valid = 1'b0;
`endif
        step();
        chk("t3_second", 32'(mux_out), 32'h33);
        chk("t3_second_v", 32'(out_valid), 32'h1);
        in_valid = 1'b0;
        step();
        chk("t3_drain_v", 32'(out_valid), 32'h0);
        chk("t3_keep", 32'(mux_out), 32'h33);

        // reset while a word is pending
        mux_sel = 2'd3;
        in_valid = 1'b1;
        out_ready = 1'b0;
        step();
        chk("t5_load", 32'(mux_out), 32'h44);
        in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        chk("t5_valid", 32'(out_valid), 32'h0);
        chk("t5_out", 32'(mux_out), 32'h0);
        chk("t5_err", 32'(sel_err), 32'h0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_lost", 32'(out_valid), 32'h0);
        end

        // NUM_IN=3 out-of-range select
        in_bus3 = 24'h332211;
        mux_sel3 = 2'd3;
        in_valid3 = 1'b1;
        out_ready3 = 1'b1;
        step();
        chk("t4_out", 32'(mux_out3), 32'h11);
        chk("t4_err", 32'(sel_err3), 32'h1);
        chk("t4_valid", 32'(out_valid3), 32'h1);
        mux_sel3 = 2'd1;
        step();
        chk("t4_out2", 32'(mux_out3), 32'h22);
        chk("t4_err2", 32'(sel_err3), 32'h0);
        in_valid3 = 1'b0;

        // random stream with scoreboard
        for (int c = 0; c < 4000; c++) begin
            in_bus = $urandom;
            mux_sel = 2'($urandom_range(0, 3));
            in_valid = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            #1;
            ixf = in_valid && in_ready;
            oxf = out_valid && out_ready;
            stall = out_valid && !out_ready;
            hold_w = mux_out;
            hold_e = sel_err;
            if (oxf) begin
                if (q.size() == 0) begin
                    chk("rnd_spurious", 32'(oxf), 32'h0);
                end else begin
                    head = q.pop_front();
                    chk("rnd_word", 32'(mux_out), 32'(head[7:0]));
                    chk("rnd_err", 32'(sel_err), 32'(head[8]));
                end
            end
            if (ixf) q.push_back({1'b0, in_bus[mux_sel*8 +: 8]});
            step();
            chk("rnd_valid", 32'(out_valid), 32'(q.size() != 0));
            if (stall) begin
                chk("rnd_hold_w", 32'(mux_out), 32'(hold_w));
                chk("rnd_hold_e", 32'(sel_err), 32'(hold_e));
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10 && q.size() != 0; c++) begin
            #1;
            if (out_valid) begin
                head = q.pop_front();
                chk("drain_word", 32'(mux_out), 32'(head[7:0]));
            end
            step();
        end
        chk("drain_empty", 32'(q.size()), 32'h0);
        chk("drain_valid", 32'(out_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
